// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibits the clock, issues a start bit, shifts out
// 8 data bits, odd parity and stop on device clock falling edges, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kclk,
  input  logic       kdata,
  output logic       kclk_oe,
  output logic       kdata_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_XFER,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Handshake: a byte is taken on any cycle with tx_valid && tx_ready; tx_ready is high
  // only in S_IDLE, so requests made while busy are dropped rather than queued.
  state_t state, state_n;

  logic kclk_s1, kclk_s2, kclk_d;
  logic kdata_s1, kdata_s2;
  logic fall;
  logic parity;
  logic timeout;

  logic [7:0]       data_q, data_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             drive_q, drive_n;

  // Synchronizers idle high so a released bus never looks like a falling edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_s1  <= 1'b1;
      kclk_s2  <= 1'b1;
      kclk_d   <= 1'b1;
      kdata_s1 <= 1'b1;
      kdata_s2 <= 1'b1;
    end else begin
      kclk_s1  <= kclk;
      kclk_s2  <= kclk_s1;
      kclk_d   <= kclk_s2;
      kdata_s1 <= kdata;
      kdata_s2 <= kdata_s1;
    end
  end

  assign fall    = kclk_d & ~kclk_s2;
  assign parity  = ~^data_q;
  assign timeout = (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      data_q  <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      drive_q <= 1'b0;
    end else begin
      state   <= state_n;
      data_q  <= data_n;
      bit_cnt <= bit_cnt_n;
      inh_cnt <= inh_cnt_n;
      to_cnt  <= to_cnt_n;
      drive_q <= drive_n;
    end
  end

  always_comb begin
    state_n   = state;
    data_n    = data_q;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    drive_n   = drive_q;
    to_cnt_n  = timeout ? to_cnt : to_cnt + 1'b1;
    tx_ready  = 1'b0;
    kclk_oe   = 1'b0;
    kdata_oe  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;

    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        tx_ready = 1'b1;
        to_cnt_n = '0;
        if (tx_valid) begin
          data_n    = tx_data;
          inh_cnt_n = '0;
          state_n   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        kclk_oe  = 1'b1;
        kdata_oe = (inh_cnt == INH_LAST);
        if (inh_cnt == INH_LAST) begin
          to_cnt_n = '0;
          state_n  = S_START;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end

      S_START: begin
        kdata_oe  = 1'b1;
        bit_cnt_n = '0;
        if (fall) begin
          bit_cnt_n = 4'd1;
          drive_n   = ~data_q[0];
          to_cnt_n  = '0;
          state_n   = S_XFER;
        end else if (timeout) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end
      end

      // bit_cnt holds the number of edges seen; edge k+1 presents data bit k, then parity, then stop.
      S_XFER: begin
        kdata_oe = drive_q;
        if (fall) begin
          to_cnt_n  = '0;
          bit_cnt_n = bit_cnt + 4'd1;
          case (bit_cnt)
            4'd8:    drive_n = ~parity;
            4'd9: begin
              drive_n = 1'b0;
              state_n = S_ACK;
            end
            default: drive_n = ~data_q[bit_cnt[2:0]];
          endcase
        end else if (timeout) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_ACK: begin
        if (fall) begin
          to_cnt_n = '0;
          if (kdata_s2) begin
            err     = 1'b1;
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT_IDLE;
          end
        end else if (timeout) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (kclk_s2 && kdata_s2) begin
          done    = 1'b1;
          state_n = S_IDLE;
        end else if (timeout) begin
          err     = 1'b1;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
